// File: rtl/nios_system_audio_ring_writer_pkg.sv
// Shared types and helpers for the audio ring writer.
// Optional build macro used by the top level: RING_WRITER_DROP_CNT_EN.
package audio_ring_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } ring_state_e;

    localparam int IRQ_HALF_BIT = 0;
    localparam int IRQ_WRAP_BIT = 1;

    function automatic logic [31:0] pack_pair(input logic [15:0] l, input logic [15:0] r);
        return {l, r};
    endfunction

endpackage

// File: rtl/nios_system_audio_ring_writer_if.sv
// Avalon-MM write-master bundle between the ring writer and the sample RAM.
interface nios_system_audio_ring_writer_if #(
    parameter int ADDR_W = 14
) ();
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
        output avm_waitrequest
    );
endinterface

// File: rtl/nios_system_audio_ring_writer_ptr.sv
// Ring write pointer, fill level against the sampled software read pointer,
// and the half/wrap interrupt flags raised as the pointer crosses those slots.
module audio_ring_ptr
    import audio_ring_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [ADDR_W-1:0] sw_rd_ptr,
    input  logic [1:0]        irq_ack,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              half_flag,
    output logic              wrap_flag
);
    localparam logic [ADDR_W-1:0] PTR_MASK  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] HALF_LAST = ADDR_W'(DEPTH / 2 - 1);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic              half_r;
    logic              wrap_r;
    logic              set_half_s;
    logic              set_wrap_s;
    logic [ADDR_W-1:0] diff_s;

    // Crossing detection and ring-relative distance.
    always_comb begin
        set_half_s = advance & (wr_ptr_r == HALF_LAST);
        set_wrap_s = advance & (wr_ptr_r == PTR_MASK);
        diff_s     = (wr_ptr_r - rd_ptr_r) & PTR_MASK;
    end

    // Pointer, sampled read pointer and sticky flags; a set beats a same-cycle ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            half_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            rd_ptr_r <= sw_rd_ptr;
            if (advance) begin
                wr_ptr_r <= (wr_ptr_r + ADDR_W'(1'b1)) & PTR_MASK;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            half_r <= set_half_s | (half_r & ~irq_ack[IRQ_HALF_BIT]);
            wrap_r <= set_wrap_s | (wrap_r & ~irq_ack[IRQ_WRAP_BIT]);
        end
    end

    assign wr_ptr    = wr_ptr_r;
    assign level     = {1'b0, diff_s};
    assign full      = (diff_s == PTR_MASK);
    assign half_flag = half_r;
    assign wrap_flag = wrap_r;

endmodule

// File: rtl/nios_system_audio_ring_writer.sv
// Stereo PCM to circular-buffer writer: one {L,R} word per accepted pair via Avalon-MM.
// Build macro RING_WRITER_DROP_CNT_EN adds a saturating drop_count output.
module nios_system_audio_ring_writer
    import audio_ring_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384,
    parameter int BASE   = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [15:0]                     in_left,
    input  logic [15:0]                     in_right,
    nios_system_audio_ring_writer_if.master avm,
    input  logic [ADDR_W-1:0]               sw_rd_ptr,
    output logic [ADDR_W-1:0]               wr_ptr,
    output logic [ADDR_W:0]                 level,
    output logic                            overflow,
    output logic                            irq,
    output logic [1:0]                      irq_status,
    input  logic [1:0]                      irq_ack
`ifdef RING_WRITER_DROP_CNT_EN
    ,
    output logic [15:0]                     drop_count
`endif
);
    ring_state_e       state_r;
    logic              hold_full_r;
    logic [31:0]       hold_data_r;
    logic [ADDR_W-1:0] addr_r;
    logic              write_r;
    logic              overflow_r;
    logic              accept_s;
    logic              take_s;
    logic              drop_s;
    logic              done_s;
    logic              full_s;
    logic              half_s;
    logic              wrap_s;

    // Handshake decode: a pair accepted while the ring is full is dropped, not held.
    always_comb begin
        in_ready = enable & ~hold_full_r;
        accept_s = in_valid & in_ready;
        take_s   = accept_s & ~full_s;
        drop_s   = accept_s & full_s;
        done_s   = write_r & ~avm.avm_waitrequest;
    end

    audio_ring_ptr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ptr (
        .clk       (clk),
        .reset     (reset),
        .advance   (done_s),
        .sw_rd_ptr (sw_rd_ptr),
        .irq_ack   (irq_ack),
        .wr_ptr    (wr_ptr),
        .level     (level),
        .full      (full_s),
        .half_flag (half_s),
        .wrap_flag (wrap_s)
    );

    // Write FSM with the one-entry hold register and the registered Avalon request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            hold_full_r <= 1'b0;
            hold_data_r <= 32'h0000_0000;
            addr_r      <= {ADDR_W{1'b0}};
            write_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        hold_full_r <= 1'b1;
                        hold_data_r <= pack_pair(in_left, in_right);
                        addr_r      <= ADDR_W'(BASE) + wr_ptr;
                        write_r     <= 1'b1;
                        state_r     <= WRITE;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                WRITE: begin
                    if (done_s) begin
                        hold_full_r <= 1'b0;
                        write_r     <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= WRITE;
                    end
                end
                default: begin
                    hold_full_r <= 1'b0;
                    write_r     <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as the ack keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= drop_s | (overflow_r & ~irq_ack[IRQ_WRAP_BIT]);
        end
    end

`ifdef RING_WRITER_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating drop counter; a same-cycle ack restarts the count at this drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s) begin
            if (irq_ack[IRQ_WRAP_BIT]) begin
                drop_cnt_r <= 16'h0001;
            end else if (drop_cnt_r != 16'hFFFF) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else if (irq_ack[IRQ_WRAP_BIT]) begin
            drop_cnt_r <= 16'h0000;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_count = drop_cnt_r;
`else
    // Without the counter only the sticky overflow bit records drops.
`endif

    assign avm.avm_address    = addr_r;
    assign avm.avm_byteenable = 4'hF;
    assign avm.avm_chipselect = write_r;
    assign avm.avm_write      = write_r;
    assign avm.avm_writedata  = hold_data_r;
    assign overflow           = overflow_r;
    assign irq_status         = {wrap_s, half_s};
    assign irq                = half_s | wrap_s;

endmodule
